// File: rtl/obi_hwpe_ctrl_cut_if.sv
// OBI data-port bundle (request channel plus response channel) used on both sides of the cut.
interface obi_hwpe_ctrl_cut_if ();
  logic        req;
  logic        gnt;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        we;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req, addr, wdata, be, we,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, addr, wdata, be, we,
    output gnt, rvalid, rdata, err
  );
endinterface

// File: rtl/obi_hwpe_ctrl_cut.sv
// Registered OBI cut in front of the RedMulE control slave: one request register, one response
// register, an in-flight cap, and a timeout that answers hung accesses with an error.
module obi_hwpe_ctrl_cut #(
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned TimeoutCycles  = 1024,
  parameter logic [31:0] ErrRdata       = 32'hBADC_AB1E
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  obi_hwpe_ctrl_cut_if.slave         obi_core,
  obi_hwpe_ctrl_cut_if.master        obi_hwpe,
  output logic                       timeout_o,
  output logic                       busy_o
);

  localparam int unsigned CntW    = $clog2(MaxOutstanding + 1);
  localparam int unsigned TmoW    = (TimeoutCycles > 2) ? $clog2(TimeoutCycles) : 1;
  localparam logic [CntW-1:0] MaxCnt  = CntW'(MaxOutstanding);
  localparam logic [TmoW-1:0] TmoLast = TmoW'((TimeoutCycles == 0) ? 0 : TimeoutCycles - 1);
  localparam bit TmoEn = (TimeoutCycles != 0);

  typedef enum logic {StEmpty, StFull} a_state_e;

  a_state_e        a_state_q, a_state_d;
  logic [31:0]     addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [3:0]      be_q, be_d;
  logic            we_q, we_d, rvalid_q, rvalid_d, err_q, err_d, timeout_q, timeout_d;
  logic [CntW-1:0] out_q, out_d, drop_q, drop_d, live;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            a_valid, gnt, fwd, expire, withdraw;

  always_comb begin
    a_valid = (a_state_q == StFull);
    gnt     = obi_core.req & (~a_valid | obi_hwpe.gnt) & (out_q < MaxCnt) & ~rst_i;
    fwd     = obi_hwpe.rvalid & (drop_q == '0);
    // Transactions still waiting for an answer; one sitting in rvalid_q is already answered.
    live    = out_q - CntW'(rvalid_q);
    expire  = TmoEn & (live != '0) & (tmo_q == TmoLast) & ~fwd;
    // The oldest unanswered access never left the register: pull it back, nothing to drop later.
    withdraw = expire & a_valid & ~obi_hwpe.gnt & (live == CntW'(1));
  end

  always_comb begin
    a_state_d = a_state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    we_d      = we_q;
    unique case (a_state_q)
      StEmpty: if (gnt) a_state_d = StFull;
      StFull:  if (!gnt && (obi_hwpe.gnt || withdraw)) a_state_d = StEmpty;
      default: a_state_d = StEmpty;
    endcase
    if (gnt) begin
      addr_d  = obi_core.addr;
      wdata_d = obi_core.wdata;
      be_d    = obi_core.be;
      we_d    = obi_core.we;
    end
  end

  always_comb begin
    out_d = out_q;
    if (gnt && !rvalid_q)      out_d = out_q + CntW'(1);
    else if (!gnt && rvalid_q) out_d = out_q - CntW'(1);

    drop_d = drop_q;
    if (obi_hwpe.rvalid && drop_q != '0)             drop_d = drop_d - CntW'(1);
    if (expire && !withdraw && drop_d < MaxCnt)      drop_d = drop_d + CntW'(1);

    if (out_q == '0 || fwd || expire) tmo_d = '0;
    else                              tmo_d = tmo_q + TmoW'(1);

    rvalid_d  = fwd | expire;
    timeout_d = expire;
    rdata_d   = rdata_q;
    err_d     = err_q;
    if (fwd) begin
      rdata_d = obi_hwpe.rdata;
      err_d   = obi_hwpe.err;
    end else if (expire) begin
      rdata_d = ErrRdata;
      err_d   = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      a_state_q <= StEmpty;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      we_q      <= 1'b0;
      out_q     <= '0;
      drop_q    <= '0;
      tmo_q     <= '0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      a_state_q <= a_state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      we_q      <= we_d;
      out_q     <= out_d;
      drop_q    <= drop_d;
      tmo_q     <= tmo_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      timeout_q <= timeout_d;
    end
  end

  assign obi_core.gnt    = gnt;
  assign obi_core.rvalid = rvalid_q;
  assign obi_core.rdata  = rdata_q;
  assign obi_core.err    = err_q;
  assign obi_hwpe.req    = a_valid;
  assign obi_hwpe.addr   = addr_q;
  assign obi_hwpe.wdata  = wdata_q;
  assign obi_hwpe.be     = be_q;
  assign obi_hwpe.we     = we_q;
  assign timeout_o       = timeout_q;
  assign busy_o          = (out_q != '0);

endmodule

// File: tb/tb_obi_hwpe_ctrl_cut.sv
// Bench for obi_hwpe_ctrl_cut: directed timing scenarios, then randomized traffic against a
// transaction-level scoreboard and an in-order downstream responder with occasional hangs.
module tb_obi_hwpe_ctrl_cut;
  localparam int unsigned MaxOut = 4;
  localparam int unsigned Tmo    = 8;
  localparam logic [31:0] ErrData = 32'hBADC_AB1E;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic timeout, busy;
  always #5 clk = ~clk;

  obi_hwpe_ctrl_cut_if core_if ();
  obi_hwpe_ctrl_cut_if hwpe_if ();

  obi_hwpe_ctrl_cut #(
    .MaxOutstanding (MaxOut),
    .TimeoutCycles  (Tmo),
    .ErrRdata       (ErrData)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .obi_core  (core_if),
    .obi_hwpe  (hwpe_if),
    .timeout_o (timeout),
    .busy_o    (busy)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        we;
  } txn_t;

  typedef struct {
    int unsigned rel;
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned cyc = 0;
  int unsigned last_rel = 0;
  int unsigned n_tmo = 0;
  int unsigned low_run = 0;
  logic        prev_gnt = 1'b0;
  txn_t        up_q[$];
  txn_t        dn_q[$];
  resp_t       rsp_q[$];

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] rd_of(input logic [31:0] a);
    return a ^ 32'hA5A5_5A5A;
  endfunction

  function automatic logic err_of(input logic [31:0] a);
    return a[4] & a[3];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    core_if.req    = 1'b0;
    core_if.addr   = '0;
    core_if.wdata  = '0;
    core_if.be     = '0;
    core_if.we     = 1'b0;
    hwpe_if.gnt    = 1'b0;
    hwpe_if.rvalid = 1'b0;
    hwpe_if.rdata  = '0;
    hwpe_if.err    = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) step();
    rst = 1'b0;
  endtask

  task automatic set_req(input logic [31:0] a, input logic we);
    core_if.req   = 1'b1;
    core_if.addr  = a;
    core_if.wdata = ~a;
    core_if.be    = 4'hF;
    core_if.we    = we;
  endtask

  // One access with immediate downstream grant and a response one cycle later.
  task automatic single_txn(input string tag, input logic [31:0] a, input logic [31:0] d,
                            input logic e);
    step(); set_req(a, 1'b1); hwpe_if.gnt = 1'b1; settle();
    check_eq({tag, "_gnt"}, core_if.gnt, 1);
    step(); core_if.req = 1'b0; settle();
    check_eq({tag, "_dn_req"}, hwpe_if.req, 1);
    check_eq({tag, "_dn_addr"}, hwpe_if.addr, a);
    step(); hwpe_if.rvalid = 1'b1; hwpe_if.rdata = d; hwpe_if.err = e; settle();
    check_eq({tag, "_rvalid_early"}, core_if.rvalid, 0);
    check_eq({tag, "_dn_req_clr"}, hwpe_if.req, 0);
    step(); hwpe_if.rvalid = 1'b0; settle();
    check_eq({tag, "_rvalid"}, core_if.rvalid, 1);
    check_eq({tag, "_rdata"}, core_if.rdata, d);
    check_eq({tag, "_err"}, core_if.err, e);
    check_eq({tag, "_busy_hold"}, busy, 1);
    step(); settle();
    check_eq({tag, "_busy_done"}, busy, 0);
  endtask

  // Random traffic cycle: drive after the edge, observe at the falling edge.
  task automatic rnd_cycle(input bit allow_req);
    resp_t r;
    txn_t  t, e;
    int unsigned lat;
    step();
    if (!(core_if.req && !prev_gnt)) begin
      if (allow_req && $urandom_range(0, 9) < 6) begin
        core_if.req   = 1'b1;
        core_if.addr  = $urandom & 32'hFFFF_FFFC;
        core_if.wdata = $urandom;
        core_if.be    = 4'($urandom);
        core_if.we    = 1'($urandom);
      end else begin
        core_if.req = 1'b0;
      end
    end
    if (!allow_req) core_if.req = 1'b0;
    hwpe_if.gnt = (low_run >= 3) ? 1'b1 : ($urandom_range(0, 3) != 0);
    low_run = hwpe_if.gnt ? 0 : low_run + 1;
    hwpe_if.rvalid = 1'b0;
    if (rsp_q.size() != 0 && rsp_q[0].rel <= cyc) begin
      r = rsp_q.pop_front();
      hwpe_if.rvalid = 1'b1;
      hwpe_if.rdata  = r.rdata;
      hwpe_if.err    = r.err;
    end
    @(negedge clk);
    check_eq("rnd_busy", busy, up_q.size() != 0);
    if (up_q.size() >= MaxOut) check_eq("rnd_gnt_cap", core_if.gnt, 0);
    check_eq("rnd_gnt_no_req", core_if.gnt & ~core_if.req, 0);
    if (timeout) check_eq("rnd_tmo_rvalid", core_if.rvalid, 1);
    if (core_if.rvalid) begin
      if (up_q.size() == 0) begin
        check_eq("rnd_rsp_unexpected", core_if.rvalid, 0);
      end else begin
        e = up_q.pop_front();
        if (timeout) begin
          n_tmo++;
          check_eq("rnd_tmo_err", core_if.err, 1);
          check_eq("rnd_tmo_rdata", core_if.rdata, ErrData);
        end else begin
          check_eq("rnd_rdata", core_if.rdata, rd_of(e.addr));
          check_eq("rnd_err", core_if.err, err_of(e.addr));
        end
      end
    end
    if (hwpe_if.req) begin
      if (dn_q.size() == 0) begin
        check_eq("rnd_dn_unexpected", hwpe_if.req, 0);
      end else begin
        check_eq("rnd_dn_addr", hwpe_if.addr, dn_q[0].addr);
        check_eq("rnd_dn_attr", {hwpe_if.we, hwpe_if.be, hwpe_if.wdata},
                 {dn_q[0].we, dn_q[0].be, dn_q[0].wdata});
        if (hwpe_if.gnt) begin
          e = dn_q.pop_front();
          lat = ($urandom_range(0, 11) == 0) ? 20 : $urandom_range(1, 4);
          r.rel = (cyc + lat > last_rel + 1) ? cyc + lat : last_rel + 1;
          r.rdata = rd_of(e.addr);
          r.err = err_of(e.addr);
          last_rel = r.rel;
          rsp_q.push_back(r);
        end
      end
    end
    if (core_if.req && core_if.gnt) begin
      t = '{addr: core_if.addr, wdata: core_if.wdata, be: core_if.be, we: core_if.we};
      up_q.push_back(t);
      dn_q.push_back(t);
    end
    prev_gnt = core_if.gnt;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int g;
    int tc;
    logic [31:0] a;

    // Reset state, with a request already pending.
    idle_inputs();
    core_if.req = 1'b1;
    hwpe_if.gnt = 1'b1;
    #2;
    check_eq("rst_gnt", core_if.gnt, 0);
    check_eq("rst_rvalid", core_if.rvalid, 0);
    check_eq("rst_dn_req", hwpe_if.req, 0);
    check_eq("rst_timeout", timeout, 0);
    check_eq("rst_busy", busy, 0);

    // Single write, +1 request / +1 response latency.
    do_reset();
    single_txn("t1", 32'h0000_0100, 32'hCAFE_0001, 1'b0);
    single_txn("t1e", 32'h0000_0104, 32'hCAFE_0002, 1'b1);

    // Back-to-back reads, no responses: in-flight cap, then timeouts drain everything.
    do_reset();
    hwpe_if.gnt = 1'b1;
    g = 0;
    a = 32'h200;
    for (int i = 0; i < 7; i++) begin
      step(); set_req(a, 1'b0); settle();
      if (core_if.gnt) begin g++; a += 4; end
    end
    check_eq("t2_gnts", g, MaxOut);
    check_eq("t2_gnt_held", core_if.gnt, 0);
    check_eq("t2_busy", busy, 1);
    step(); core_if.req = 1'b0;
    tc = 0;
    for (int i = 0; i < 60; i++) begin
      step(); settle();
      if (timeout) begin
        tc++;
        check_eq("t2_tmo_rvalid", core_if.rvalid, 1);
        check_eq("t2_tmo_err", core_if.err, 1);
        check_eq("t2_tmo_rdata", core_if.rdata, ErrData);
      end
    end
    check_eq("t2_timeouts", tc, MaxOut);
    check_eq("t2_drained", busy, 0);

    // Downstream stalls for 5 cycles: register holds, no further upstream grant.
    do_reset();
    step(); set_req(32'h300, 1'b0); settle();
    check_eq("t3_gnt", core_if.gnt, 1);
    step(); set_req(32'h304, 1'b0);
    g = 0;
    for (int i = 0; i < 5; i++) begin
      settle();
      check_eq("t3_dn_req", hwpe_if.req, 1);
      check_eq("t3_addr_stable", hwpe_if.addr, 32'h300);
      if (core_if.gnt) g++;
      step();
    end
    check_eq("t3_no_gnt", g, 0);
    hwpe_if.gnt = 1'b1; settle();
    check_eq("t3_reload_gnt", core_if.gnt, 1);
    step(); core_if.req = 1'b0; settle();
    check_eq("t3_reload_addr", hwpe_if.addr, 32'h304);

    // Timeout after a downstream grant, then the late response is discarded.
    do_reset();
    hwpe_if.gnt = 1'b1;
    step(); set_req(32'h400, 1'b0); settle();
    check_eq("t4_gnt", core_if.gnt, 1);
    step(); core_if.req = 1'b0;
    repeat (7) step();
    settle();
    check_eq("t4_no_early_tmo", timeout, 0);
    check_eq("t4_no_early_rvalid", core_if.rvalid, 0);
    step(); settle();
    check_eq("t4_timeout", timeout, 1);
    check_eq("t4_rvalid", core_if.rvalid, 1);
    check_eq("t4_err", core_if.err, 1);
    check_eq("t4_rdata", core_if.rdata, ErrData);
    step(); settle();
    check_eq("t4_tmo_pulse", timeout, 0);
    check_eq("t4_busy", busy, 0);
    step(); hwpe_if.rvalid = 1'b1; hwpe_if.rdata = 32'h1234_5678; hwpe_if.err = 1'b0;
    step(); hwpe_if.rvalid = 1'b0; settle();
    check_eq("t4_late_dropped", core_if.rvalid, 0);
    single_txn("t4_after", 32'h0000_0408, 32'h0BAD_F00D, 1'b0);

    // Response lands exactly in the expiry cycle: real data wins.
    do_reset();
    hwpe_if.gnt = 1'b1;
    step(); set_req(32'h500, 1'b0); settle();
    check_eq("t5_gnt", core_if.gnt, 1);
    step(); core_if.req = 1'b0;
    repeat (6) step();
    step(); hwpe_if.rvalid = 1'b1; hwpe_if.rdata = 32'h5555_AAAA; hwpe_if.err = 1'b0; settle();
    check_eq("t5_no_tmo_expiry", timeout, 0);
    step(); hwpe_if.rvalid = 1'b0; settle();
    check_eq("t5_rvalid", core_if.rvalid, 1);
    check_eq("t5_rdata", core_if.rdata, 32'h5555_AAAA);
    check_eq("t5_err", core_if.err, 0);
    check_eq("t5_no_tmo", timeout, 0);
    step(); settle();
    check_eq("t5_busy", busy, 0);

    // Timeout while the access is still in the register: withdrawn, nothing dropped afterwards.
    do_reset();
    step(); set_req(32'h700, 1'b0); settle();
    check_eq("t7_gnt", core_if.gnt, 1);
    step(); core_if.req = 1'b0;
    repeat (7) step();
    step(); settle();
    check_eq("t7_timeout", timeout, 1);
    check_eq("t7_err", core_if.err, 1);
    check_eq("t7_withdrawn", hwpe_if.req, 0);
    single_txn("t7_after", 32'h0000_0704, 32'h7777_0001, 1'b0);

    // Reset with three outstanding drops everything at once.
    do_reset();
    hwpe_if.gnt = 1'b1;
    g = 0;
    a = 32'h600;
    for (int i = 0; i < 10 && g < 3; i++) begin
      step(); set_req(a, 1'b0); settle();
      if (core_if.gnt) begin g++; a += 4; end
    end
    check_eq("t6_three_gnts", g, 3);
    step(); set_req(a, 1'b0); settle();
    check_eq("t6_pre_req", hwpe_if.req, 1);
    rst = 1'b1; settle();
    check_eq("t6_gnt", core_if.gnt, 0);
    check_eq("t6_rvalid", core_if.rvalid, 0);
    check_eq("t6_dn_req", hwpe_if.req, 0);
    check_eq("t6_busy", busy, 0);
    idle_inputs();
    step(); step();
    rst = 1'b0;
    single_txn("t6_after", 32'h0000_0680, 32'h6666_0001, 1'b0);

    // Randomized traffic against the scoreboard.
    do_reset();
    up_q.delete();
    dn_q.delete();
    rsp_q.delete();
    prev_gnt = 1'b0;
    last_rel = cyc;
    for (int i = 0; i < 3000; i++) rnd_cycle(1'b1);
    for (int i = 0; i < 400; i++) begin
      if (up_q.size() == 0 && rsp_q.size() == 0 && !hwpe_if.req) break;
      rnd_cycle(1'b0);
    end
    check_eq("rnd_drained_up", up_q.size(), 0);
    check_eq("rnd_drained_dn", rsp_q.size(), 0);
    check_eq("rnd_tmo_seen", n_tmo != 0, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
